pll_lock_ctrl: RTL and testbench

Sequencer for the iCE40 SB_PLL40_CORE: holds the PLL in reset for a fixed interval, waits for lock with a timeout and bounded retries, qualifies lock as stable, and only then releases the downstream logic reset. Runs on the PLL reference clock, never on the PLL output. Lock loss in service re-sequences the PLL and is counted.

---
 rtl/pll_ctrl_pkg.sv | 21 ++
 rtl/sync2.sv | 24 ++
 rtl/pll_lock_ctrl.sv | 151 +++++++++++++++
 tb/tb_pll_lock_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared types for the PLL lock sequencer: state encoding and loss-counter width.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4,
    ST_BYPASS    = 3'd5
  } pll_state_t;

  localparam int LOSS_CNT_W = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous single-bit status inputs; resets to 0.
module sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_ctrl.sv
// SB_PLL40_CORE reset/lock sequencer running on the reference clock.
// Define PLL_LOCK_CTRL_BYPASS_FALLBACK_EN to fall back to BYPASS instead of FAIL on retry exhaustion.
module pll_lock_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3
) (
  input  logic                  clock_in,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  pll_lock,
  output logic                  pll_resetb,
  output logic                  pll_bypass,
  output logic                  clk_ok,
  output logic                  sys_reset_n,
  output logic                  fail,
  output logic [2:0]            state,
  output logic [LOSS_CNT_W-1:0] loss_count
);

  localparam int CNT_W   = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1);
  localparam int RETRY_W = $clog2(MAX_RETRIES + 2);

`ifdef PLL_LOCK_CTRL_BYPASS_FALLBACK_EN
  localparam pll_state_t EXHAUST_ST = ST_BYPASS;
`else
  localparam pll_state_t EXHAUST_ST = ST_FAIL;
`endif

  logic                  lock_s;
  pll_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [RETRY_W-1:0]    retry_q, retry_d;
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;
  logic                  attempt_failed;
  logic                  pll_resetb_q, clk_ok_q, sys_reset_n_q, fail_q;

  sync2 u_lock_sync (
    .clk_i  (clock_in),
    .rst_ni (reset_n),
    .d_i    (pll_lock),
    .q_o    (lock_s)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q + 1'b1;
    retry_d        = retry_q;
    loss_d         = loss_q;
    attempt_failed = 1'b0;

    if (!enable) begin
      state_d = ST_RESET;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        ST_WAIT_LOCK: begin
          // Lock takes priority over a coincident timeout.
          if (lock_s) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
            attempt_failed = 1'b1;
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            attempt_failed = 1'b1;
          end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            retry_d = '0;
          end
        end
        ST_RUN: begin
          cnt_d = '0;
          if (!lock_s) begin
            state_d = ST_RESET;
            if (loss_q != '1) loss_d = loss_q + 1'b1;
          end
        end
        ST_FAIL, ST_BYPASS: cnt_d = '0;
        default: begin
          state_d = ST_RESET;
          cnt_d   = '0;
        end
      endcase

      if (attempt_failed) begin
        cnt_d   = '0;
        retry_d = retry_q + 1'b1;
        state_d = (int'(retry_q) >= MAX_RETRIES) ? EXHAUST_ST : ST_RESET;
      end
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as state.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_RESET;
      cnt_q         <= '0;
      retry_q       <= '0;
      loss_q        <= '0;
      pll_resetb_q  <= 1'b0;
      clk_ok_q      <= 1'b0;
      sys_reset_n_q <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      loss_q        <= loss_d;
      pll_resetb_q  <= (state_d == ST_WAIT_LOCK) || (state_d == ST_STABLE) ||
                       (state_d == ST_RUN) || (state_d == ST_BYPASS);
      clk_ok_q      <= (state_d == ST_RUN);
      sys_reset_n_q <= (state_d == ST_RUN) || (state_d == ST_BYPASS);
      fail_q        <= (state_d == ST_FAIL) || (state_d == ST_BYPASS);
    end
  end

`ifdef PLL_LOCK_CTRL_BYPASS_FALLBACK_EN
  logic pll_bypass_q;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) pll_bypass_q <= 1'b0;
    else          pll_bypass_q <= (state_d == ST_BYPASS);
  end

  assign pll_bypass = pll_bypass_q;
`else
  assign pll_bypass = 1'b0;
`endif

  assign pll_resetb  = pll_resetb_q;
  assign clk_ok      = clk_ok_q;
  assign sys_reset_n = sys_reset_n_q;
  assign fail        = fail_q;
  assign state       = state_q;
  assign loss_count  = loss_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl with RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=1.
module tb_pll_lock_ctrl;

  logic       clock_in = 1'b0;
  logic       reset_n  = 1'b0;
  logic       enable   = 1'b0;
  logic       pll_lock = 1'b0;
  logic       pll_resetb, pll_bypass, clk_ok, sys_reset_n, fail;
  logic [2:0] state;
  logic [7:0] loss_count;

  int tests = 0;
  int fails = 0;

`ifdef PLL_LOCK_CTRL_BYPASS_FALLBACK_EN
  localparam logic [2:0] EXH_STATE  = 3'd5;
  localparam logic       EXH_RESETB = 1'b1;
  localparam logic       EXH_BYP    = 1'b1;
  localparam logic       EXH_SRN    = 1'b1;
`else
  localparam logic [2:0] EXH_STATE  = 3'd4;
  localparam logic       EXH_RESETB = 1'b0;
  localparam logic       EXH_BYP    = 1'b0;
  localparam logic       EXH_SRN    = 1'b0;
`endif

  pll_lock_ctrl #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (1)
  ) dut (
    .clock_in    (clock_in),
    .reset_n     (reset_n),
    .enable      (enable),
    .pll_lock    (pll_lock),
    .pll_resetb  (pll_resetb),
    .pll_bypass  (pll_bypass),
    .clk_ok      (clk_ok),
    .sys_reset_n (sys_reset_n),
    .fail        (fail),
    .state       (state),
    .loss_count  (loss_count)
  );

  always #5 clock_in = ~clock_in;

  task automatic tick(input int n);
    repeat (n) @(posedge clock_in);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (state == s) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b1; pll_lock = 1'b0;
    tick(3);
    tests++; if (state !== 3'd0) begin fails++; $display("FAIL reset_state act=%0d req=0", state); end
    tests++; if ({pll_resetb, pll_bypass, clk_ok, sys_reset_n, fail} !== 5'b00000) begin
      fails++; $display("FAIL reset_outs act=%b req=00000", {pll_resetb, pll_bypass, clk_ok, sys_reset_n, fail}); end
    tests++; if (loss_count !== 8'd0) begin fails++; $display("FAIL reset_loss act=%0d req=0", loss_count); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_lock_seq();
    reset_n = 1'b1;
    tick(3);
    tests++; if (pll_resetb !== 1'b0) begin fails++; $display("FAIL seq_resetb_c3 act=%b req=0", pll_resetb); end
    tick(1);
    tests++; if (pll_resetb !== 1'b1) begin fails++; $display("FAIL seq_resetb_c4 act=%b req=1", pll_resetb); end
    tests++; if (state !== 3'd1) begin fails++; $display("FAIL seq_wait_state act=%0d req=1", state); end
    tick(10);
    pll_lock = 1'b1;
    tick(2);
    tests++; if (state !== 3'd1) begin fails++; $display("FAIL seq_sync_lat act=%0d req=1", state); end
    tick(1);
    tests++; if (state !== 3'd2) begin fails++; $display("FAIL seq_stable_entry act=%0d req=2", state); end
    tick(7);
    tests++; if ({sys_reset_n, state} !== {1'b0, 3'd2}) begin
      fails++; $display("FAIL seq_pre_run act=%b/%0d req=0/2", sys_reset_n, state); end
    tick(1);
    tests++; if ({sys_reset_n, clk_ok, state} !== {1'b1, 1'b1, 3'd3}) begin
      fails++; $display("FAIL seq_run act=%b%b/%0d req=11/3", sys_reset_n, clk_ok, state); end
    $display("[TB] test_lock_seq done");
  endtask

  task automatic test_loss();
    bit ok;
    for (int i = 1; i <= 3; i++) begin
      pll_lock = 1'b0;
      tick(2);
      tests++; if (sys_reset_n !== 1'b1) begin fails++; $display("FAIL loss_early_%0d act=%b req=1", i, sys_reset_n); end
      tick(1);
      tests++; if ({sys_reset_n, clk_ok, state} !== {1'b0, 1'b0, 3'd0}) begin
        fails++; $display("FAIL loss_drop_%0d act=%b%b/%0d req=00/0", i, sys_reset_n, clk_ok, state); end
      tests++; if (loss_count !== 8'(i)) begin fails++; $display("FAIL loss_count_%0d act=%0d req=%0d", i, loss_count, i); end
      pll_lock = 1'b1;
      wait_state(3'd3, 40, ok);
      tests++; if (!ok) begin fails++; $display("FAIL loss_relock_%0d act=state%0d req=state3", i, state); end
    end
    for (int i = 4; i <= 255; i++) begin
      pll_lock = 1'b0;
      tick(3);
      pll_lock = 1'b1;
      wait_state(3'd3, 40, ok);
      tests++; if (!ok) begin fails++; $display("FAIL sat_relock_%0d act=state%0d req=state3", i, state); end
    end
    tests++; if (loss_count !== 8'd255) begin fails++; $display("FAIL sat_reach act=%0d req=255", loss_count); end
    for (int i = 0; i < 2; i++) begin
      pll_lock = 1'b0;
      tick(3);
      tests++; if (loss_count !== 8'd255) begin fails++; $display("FAIL sat_hold_%0d act=%0d req=255", i, loss_count); end
      pll_lock = 1'b1;
      wait_state(3'd3, 40, ok);
      tests++; if (!ok) begin fails++; $display("FAIL sat_relock_x%0d act=state%0d req=state3", i, state); end
    end
    $display("[TB] test_loss done, loss_count=%0d", loss_count);
  endtask

  task automatic test_timeout();
    pll_lock = 1'b0;
    reset_n  = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(23);
    tests++; if (state !== 3'd1) begin fails++; $display("FAIL to_att1_wait act=%0d req=1", state); end
    tick(1);
    tests++; if (state !== 3'd0) begin fails++; $display("FAIL to_att1_end act=%0d req=0", state); end
    tick(23);
    tests++; if ({fail, state} !== {1'b0, 3'd1}) begin fails++; $display("FAIL to_att2_wait act=%b/%0d req=0/1", fail, state); end
    tick(1);
    tests++; if (state !== EXH_STATE) begin fails++; $display("FAIL to_exh_state act=%0d req=%0d", state, EXH_STATE); end
    tests++; if ({fail, pll_resetb, pll_bypass, sys_reset_n, clk_ok} !== {1'b1, EXH_RESETB, EXH_BYP, EXH_SRN, 1'b0}) begin
      fails++; $display("FAIL to_exh_outs act=%b req=%b", {fail, pll_resetb, pll_bypass, sys_reset_n, clk_ok},
                        {1'b1, EXH_RESETB, EXH_BYP, EXH_SRN, 1'b0}); end
    tick(5);
    tests++; if (state !== EXH_STATE) begin fails++; $display("FAIL to_terminal act=%0d req=%0d", state, EXH_STATE); end
    $display("[TB] test_timeout done");
  endtask

  task automatic test_enable_in_fail();
    enable = 1'b0;
    tick(1);
    tests++; if ({fail, pll_resetb, state} !== {1'b0, 1'b0, 3'd0}) begin
      fails++; $display("FAIL en_exit act=%b%b/%0d req=00/0", fail, pll_resetb, state); end
    tick(2);
    enable = 1'b1;
    tick(3);
    tests++; if (state !== 3'd0) begin fails++; $display("FAIL en_rst_c3 act=%0d req=0", state); end
    tick(1);
    tests++; if (state !== 3'd1) begin fails++; $display("FAIL en_rst_c4 act=%0d req=1", state); end
    tick(20);
    tests++; if (state !== 3'd0) begin fails++; $display("FAIL en_att1_end act=%0d req=0", state); end
    tick(23);
    tests++; if (state !== 3'd1) begin fails++; $display("FAIL en_att2_wait act=%0d req=1", state); end
    tick(1);
    tests++; if (state !== EXH_STATE) begin fails++; $display("FAIL en_exh act=%0d req=%0d", state, EXH_STATE); end
    $display("[TB] test_enable_in_fail done");
  endtask

  task automatic test_glitch();
    enable = 1'b0;
    tick(1);
    enable = 1'b1;
    tick(4);
    pll_lock = 1'b1;
    tick(3);
    tests++; if (state !== 3'd2) begin fails++; $display("FAIL gl_stable act=%0d req=2", state); end
    tick(4);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(1);
    tests++; if (state !== 3'd2) begin fails++; $display("FAIL gl_hold act=%0d req=2", state); end
    tick(1);
    tests++; if ({clk_ok, state} !== {1'b0, 3'd0}) begin fails++; $display("FAIL gl_reset act=%b/%0d req=0/0", clk_ok, state); end
    tick(12);
    tests++; if ({sys_reset_n, state} !== {1'b0, 3'd2}) begin
      fails++; $display("FAIL gl_requal act=%b/%0d req=0/2", sys_reset_n, state); end
    tick(1);
    tests++; if ({sys_reset_n, state} !== {1'b1, 3'd3}) begin
      fails++; $display("FAIL gl_run act=%b/%0d req=1/3", sys_reset_n, state); end
    // Glitch again but leave the lock low: the counted retry must exhaust on the next timeout.
    pll_lock = 1'b0;
    enable   = 1'b0;
    tick(1);
    enable = 1'b1;
    tick(4);
    pll_lock = 1'b1;
    tick(7);
    pll_lock = 1'b0;
    tick(3);
    tests++; if (state !== 3'd0) begin fails++; $display("FAIL gl2_reset act=%0d req=0", state); end
    tick(23);
    tests++; if (state !== 3'd1) begin fails++; $display("FAIL gl2_wait act=%0d req=1", state); end
    tick(1);
    tests++; if (state !== EXH_STATE) begin fails++; $display("FAIL gl2_exh act=%0d req=%0d", state, EXH_STATE); end
    $display("[TB] test_glitch done");
  endtask

  task automatic test_reset_mid_stable();
    bit ok;
    enable = 1'b0;
    tick(1);
    enable   = 1'b1;
    pll_lock = 1'b1;
    wait_state(3'd3, 30, ok);
    tests++; if (!ok) begin fails++; $display("FAIL rm_run act=state%0d req=state3", state); end
    pll_lock = 1'b0;
    tick(3);
    tests++; if (loss_count !== 8'd1) begin fails++; $display("FAIL rm_loss act=%0d req=1", loss_count); end
    pll_lock = 1'b1;
    wait_state(3'd2, 20, ok);
    tick(2);
    tests++; if (!ok || {pll_resetb, state} !== {1'b1, 3'd2}) begin
      fails++; $display("FAIL rm_in_stable act=%b/%0d req=1/2", pll_resetb, state); end
    reset_n = 1'b0;
    #2;
    tests++; if (state !== 3'd0 || loss_count !== 8'd0) begin
      fails++; $display("FAIL rm_async_state act=%0d/%0d req=0/0", state, loss_count); end
    tests++; if ({pll_resetb, pll_bypass, clk_ok, sys_reset_n, fail} !== 5'b00000) begin
      fails++; $display("FAIL rm_async_outs act=%b req=00000", {pll_resetb, pll_bypass, clk_ok, sys_reset_n, fail}); end
    reset_n = 1'b1;
    tick(2);
    $display("[TB] test_reset_mid_stable done");
  endtask

  initial begin
    test_reset();
    test_lock_seq();
    test_loss();
    test_timeout();
    test_enable_in_fail();
    test_glitch();
    test_reset_mid_stable();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
